od_line_rx: RTL and testbench
=============================

Name: od_line_rx

Overview:
- Receiving end of a single open-drain serial line. Remote transmitters drive the line only through nmos pull-down switches; an external pull-up holds it high otherwise.
- Deserializes UART-style frames: start bit low, DATA_W data bits LSB first, stop bit high.
- Presents each received word on a valid/ready output with a one-entry holding buffer.
- Sits at the switch-level/RTL boundary: its input sees 0, 1 or z.

Parameters:
- CLKS_PER_BIT, 16, clock cycles per bit period; must be even and at least 4.
- DATA_W, 8, data bits per frame.

Ports:
- clk  in  1  sole clock, rising edge.
- rstn  in  1  synchronous, active-low reset.
- line  in  1  open-drain serial line; z or x is interpreted as 1 (pulled up).
- rx_data  out  DATA_W  received word; stable while rx_valid=1.
- rx_valid  out  1  holding buffer full.
- rx_ready  in  1  consumer accepts when rx_valid && rx_ready at a rising edge.
- busy  out  1  high in every FSM state except IDLE.
- frame_err  out  1  one-cycle pulse on bad stop bit.
- overrun  out  1  one-cycle pulse when a completed frame is dropped.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low (rstn sampled on the rising edge of clk).
- Reset values:
  - rx_data=0, rx_valid=0, busy=0, frame_err=0, overrun=0.
  - FSM=IDLE, synchronizer flops=1, bit and sample counters=0.
- Input conditioning:
  - line is normalized: any value other than 0 counts as 1 (in simulation, compare line === 1'b0).
  - It then passes through a 2-flop synchronizer. The synchronized value is s_line, delayed 2 cycles.
- FSM states: IDLE, START, DATA, STOP, BREAK.
  - IDLE: a 1→0 transition on s_line loads the sample counter and moves to START.
  - START: wait CLKS_PER_BIT/2 cycles, then re-sample.
    - s_line=0: go to DATA, bit index 0.
    - s_line=1: glitch; return to IDLE with no output and no error.
  - DATA: sample s_line every CLKS_PER_BIT cycles into bit index 0..DATA_W-1 (LSB first). After bit DATA_W-1, go to STOP.
  - STOP: sample after CLKS_PER_BIT cycles.
    - s_line=1: frame good; deliver it and go to IDLE.
    - s_line=0: pulse frame_err, discard the word, go to BREAK.
  - BREAK: stay until s_line=1, then go to IDLE. No new start bit is detected while in BREAK.
- Delivery: rx_data and rx_valid update on the edge after the stop-bit sample.
  - Latency: falling edge on line → rx_valid is 2 sync cycles + CLKS_PER_BIT/2 + (DATA_W+1)·CLKS_PER_BIT + 1 cycles.
- Holding buffer:
  - rx_valid stays high until accepted (rx_valid && rx_ready).
  - rx_data must not change while rx_valid=1 unless it is replaced in the same cycle as an accept.
  - A good frame completes while rx_valid=1 and no accept that cycle: drop the new word, keep the old word, pulse overrun.
  - Good frame completion and accept in the same cycle: load the new word, rx_valid stays 1, no overrun.
- Back-to-back frames: a start bit may begin in the cycle after the STOP→IDLE transition.
- Reset mid-frame: abort immediately and discard the partial word. The buffer clears with rx_valid=0.
- Counter width: $clog2(CLKS_PER_BIT). The counter wraps to reload with no free-running overflow.

Optional Feature:
- Macro: OD_LINE_MAJORITY_EN.
- Defined:
  - A 3-flop shift register follows the synchronizer; s_line is the majority of its 3 taps.
  - Adds 2 cycles of latency and rejects line glitches of 1 cycle.
  - Sample points are unchanged relative to s_line.
- Undefined: s_line is the synchronizer output directly.

Decomposition:
- Package od_line_pkg:
  - state enum rx_state_t (IDLE, START, DATA, STOP, BREAK).
  - localparams SYNC_STAGES=2 and MAJ_TAPS=3.
  - function cnt_w(CLKS_PER_BIT).
- Sub-module od_line_sync:
  - Does z/x normalization, the 2-flop synchronizer and the optional majority filter.
  - Output s_line. Reset value 1 (idle).
- od_line_rx top holds the FSM, counters, shift register and holding buffer.

Test Plan (CLKS_PER_BIT=8, DATA_W=8):
- Good frame: drive line via nmos model with 0xA5, rx_ready=1 → rx_valid pulses once with rx_data=0xA5; frame_err=0, overrun=0.
- Glitch: line low 2 cycles, then z (pull-up) → no rx_valid, no frame_err, busy returns to 0 within 6 cycles. With OD_LINE_MAJORITY_EN, a 1-cycle low never sets busy.
- Bad stop: send 0x3C with stop bit held 0 for 3 bit times → frame_err pulses once, no rx_valid. FSM waits in BREAK until line releases, then receives next frame 0x11 correctly.
- Overrun: rx_ready=0, send 0x01 then 0x02 → rx_data stays 0x01, overrun pulses once at the second stop bit. Then raise rx_ready with a simultaneous completion of 0x03 → 0x03 is loaded, no overrun.
- Idle z: line held z for 200 cycles → busy=0, no outputs asserted.
- Reset mid-frame: assert rstn=0 during data bit 4 of 0xFF, release, send 0x5A → only 0x5A is delivered; outputs were at reset values during rstn=0.

Source files
------------

// File: rtl/od_line_pkg.sv
// Shared types and sizing helpers for the open-drain line receiver.
package od_line_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } rx_state_t;

    localparam int unsigned SYNC_STAGES = 2;
    localparam int unsigned MAJ_TAPS    = 3;

    // Sample counter width; the counter only ever holds 0..CLKS_PER_BIT-1.
    function automatic int unsigned cnt_w(input int unsigned clks_per_bit);
        return $clog2(clks_per_bit);
    endfunction

endpackage

// File: rtl/od_line_sync.sv
// Open-drain line conditioning: z/x -> 1, 2-flop synchronizer, and an optional
// 3-tap majority filter enabled by OD_LINE_MAJORITY_EN.
module od_line_sync
    import od_line_pkg::*;
(
    input  logic clk,
    input  logic rstn,
    input  logic line,
    output logic s_line
);

    logic                   line_n;
    logic [SYNC_STAGES-1:0] sync_q;

    // Only an actively pulled-down line reads as 0; z/x is the pulled-up idle level.
    always_comb line_n = (line === 1'b0) ? 1'b0 : 1'b1;

    always_ff @(posedge clk) begin
        if (!rstn) sync_q <= '1;
        else       sync_q <= {sync_q[SYNC_STAGES-2:0], line_n};
    end

`ifdef OD_LINE_MAJORITY_EN
    logic [MAJ_TAPS-1:0] maj_q;

    always_ff @(posedge clk) begin
        if (!rstn) maj_q <= '1;
        else       maj_q <= {maj_q[MAJ_TAPS-2:0], sync_q[SYNC_STAGES-1]};
    end

    // Two of three taps must agree, so a single-cycle glitch never reaches the FSM.
    always_comb s_line = (maj_q[0] & maj_q[1]) | (maj_q[0] & maj_q[2]) | (maj_q[1] & maj_q[2]);
`else
    always_comb s_line = sync_q[SYNC_STAGES-1];
`endif

endmodule

// File: rtl/od_line_rx.sv
// UART-style receiver for an open-drain line with a one-entry valid/ready buffer.
// Building with OD_LINE_MAJORITY_EN adds a majority glitch filter in od_line_sync.
module od_line_rx
    import od_line_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned DATA_W       = 8
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              line,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              busy,
    output logic              frame_err,
    output logic              overrun
);

    localparam int unsigned CNT_W = cnt_w(CLKS_PER_BIT);
    localparam int unsigned BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int unsigned HALF  = CLKS_PER_BIT / 2;

    rx_state_t         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              good_c, bad_c;
    logic              s_line;

    od_line_sync u_sync (
        .clk    (clk),
        .rstn   (rstn),
        .line   (line),
        .s_line (s_line)
    );

    // Next-state, bit sampling and frame completion events.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        good_c  = 1'b0;
        bad_c   = 1'b0;
        unique case (state_q)
            IDLE: begin
                // Every path into IDLE leaves s_line high, so a low level is the falling edge.
                if (!s_line) begin
                    state_d = START;
                    cnt_d   = CNT_W'(HALF - 1);
                end
            end
            START: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (!s_line) begin
                    state_d = DATA;
                    cnt_d   = CNT_W'(CLKS_PER_BIT - 1);
                    bit_d   = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            DATA: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    shift_d = DATA_W'({s_line, shift_q} >> 1);
                    cnt_d   = CNT_W'(CLKS_PER_BIT - 1);
                    if (bit_q == BIT_W'(DATA_W - 1)) state_d = STOP;
                    else                             bit_d   = bit_q + 1'b1;
                end
            end
            STOP: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (s_line) begin
                    good_c  = 1'b1;
                    state_d = IDLE;
                end else begin
                    bad_c   = 1'b1;
                    state_d = BREAK;
                end
            end
            BREAK: begin
                if (s_line) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
        end
    end

    // Holding buffer: a new word is only taken when the slot is empty or being drained.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            busy      <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            busy      <= (state_d != IDLE);
            frame_err <= bad_c;
            overrun   <= good_c && rx_valid && !rx_ready;
            if (good_c && (!rx_valid || rx_ready)) begin
                rx_data  <= shift_q;
                rx_valid <= 1'b1;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_od_line_rx.sv
// Directed bench for od_line_rx: open-drain driver with pull-up, word scoreboard.
module tb_od_line_rx;

    localparam int CPB = 8;
    localparam int DW  = 8;
    localparam int H   = CPB / 2;
`ifdef OD_LINE_MAJORITY_EN
    localparam int EXTRA = 2;
`else
    localparam int EXTRA = 0;
`endif
    localparam int LAT = 2 + H + (DW + 1) * CPB + 1 + EXTRA;

    logic          clk = 1'b0;
    logic          rstn;
    logic          od_low;
    logic          rx_ready;
    logic [DW-1:0] rx_data;
    logic          rx_valid;
    logic          busy;
    logic          frame_err;
    logic          overrun;
    wire           line;

    // Open-drain transmitter: pull-down switch to ground, external pull-up otherwise.
    assign line = od_low ? 1'b0 : 1'bz;
    pullup (line);

    od_line_rx #(.CLKS_PER_BIT(CPB), .DATA_W(DW)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .line      (line),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .busy      (busy),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    int            cyc = 0;
    int            errors = 0;
    int            checks = 0;
    int            pops = 0;
    int            ferr_cnt = 0;
    int            ovr_cnt = 0;
    int            last_pop_cyc = 0;
    int            t0;
    logic          busy_seen = 1'b0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] exp_word;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor on the falling edge: pulses, busy history and scoreboard pops on accept.
    always @(negedge clk) begin
        if (rstn) begin
            if (busy)      busy_seen = 1'b1;
            if (frame_err) ferr_cnt++;
            if (overrun)   ovr_cnt++;
            if (rx_valid && rx_ready) begin
                pops++;
                last_pop_cyc = cyc;
                checks++;
                assert (exp_q.size() != 0) else begin
                    errors++;
                    $error("FAIL unexpected_word got %02h want none", rx_data);
                end
                if (exp_q.size() != 0) begin
                    exp_word = exp_q.pop_front();
                    checks++;
                    assert (rx_data === exp_word) else begin
                        errors++;
                        $error("FAIL rx_word got %02h want %02h", rx_data, exp_word);
                    end
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s got %0h want %0h", tag, obs, want);
        end
    endtask

    task automatic send_bit(input logic b);
        od_low = !b;
        tick(CPB);
    endtask

    // stop_low = 0 sends a good stop bit; otherwise hold the line low that many bit times.
    task automatic send_frame(input logic [DW-1:0] d, input int stop_low);
        send_bit(1'b0);
        for (int i = 0; i < DW; i++) send_bit(d[i]);
        if (stop_low == 0) send_bit(1'b1);
        else repeat (stop_low) send_bit(1'b0);
    endtask

    initial begin
        rstn     = 1'b0;
        od_low   = 1'b0;
        rx_ready = 1'b0;
        tick(3);
        check("rst_valid", 32'(rx_valid), 32'd0);
        check("rst_data", 32'(rx_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ferr", 32'(frame_err), 32'd0);
        check("rst_ovr", 32'(overrun), 32'd0);
        rstn = 1'b1;
        tick(4);

        // Good frame and end-to-end latency.
        rx_ready = 1'b1;
        exp_q.push_back(8'hA5);
        t0 = cyc;
        send_frame(8'hA5, 0);
        tick(4);
        check("good_latency", 32'(last_pop_cyc - t0), 32'(LAT));
        check("good_pops", 32'(pops), 32'd1);
        check("good_ferr", 32'(ferr_cnt), 32'd0);
        check("good_ovr", 32'(ovr_cnt), 32'd0);
        check("good_valid_clr", 32'(rx_valid), 32'd0);

        // Two-cycle glitch is rejected at the start-bit re-sample.
        busy_seen = 1'b0;
        od_low = 1'b1;
        tick(2);
        od_low = 1'b0;
        tick(6 + EXTRA);
        check("glitch_busy_seen", 32'(busy_seen), 32'd1);
        check("glitch_busy_idle", 32'(busy), 32'd0);
        tick(20);
        check("glitch_pops", 32'(pops), 32'd1);
        check("glitch_ferr", 32'(ferr_cnt), 32'd0);
`ifdef OD_LINE_MAJORITY_EN
        busy_seen = 1'b0;
        od_low = 1'b1;
        tick(1);
        od_low = 1'b0;
        tick(12);
        check("maj_reject", 32'(busy_seen), 32'd0);
`endif

        // Bad stop bit, wait in BREAK, then recover with a good frame.
        send_frame(8'h3C, 3);
        check("break_busy", 32'(busy), 32'd1);
        check("bad_ferr", 32'(ferr_cnt), 32'd1);
        od_low = 1'b0;
        tick(CPB);
        check("break_exit", 32'(busy), 32'd0);
        exp_q.push_back(8'h11);
        send_frame(8'h11, 0);
        tick(4);
        check("after_break_pops", 32'(pops), 32'd2);
        check("after_break_ferr", 32'(ferr_cnt), 32'd1);

        // Overrun: second word dropped while the first is held.
        rx_ready = 1'b0;
        exp_q.push_back(8'h01);
        send_frame(8'h01, 0);
        check("ovr_hold_valid", 32'(rx_valid), 32'd1);
        send_frame(8'h02, 0);
        tick(2);
        check("ovr_keep_data", 32'(rx_data), 32'h01);
        check("ovr_pulse", 32'(ovr_cnt), 32'd1);
        check("ovr_valid", 32'(rx_valid), 32'd1);

        // Accept lands on the same edge as the next completion: replace, no overrun.
        exp_q.push_back(8'h03);
        fork
            send_frame(8'h03, 0);
            begin
                tick(LAT - 1);
                rx_ready = 1'b1;
            end
        join
        tick(4);
        check("swap_ovr", 32'(ovr_cnt), 32'd1);
        check("swap_pops", 32'(pops), 32'd4);
        check("swap_valid_clr", 32'(rx_valid), 32'd0);

        // Line idle (pulled up) for a long stretch.
        busy_seen = 1'b0;
        tick(200);
        check("idle_busy", 32'(busy_seen), 32'd0);
        check("idle_pops", 32'(pops), 32'd4);
        check("idle_ferr", 32'(ferr_cnt), 32'd1);
        check("idle_ovr", 32'(ovr_cnt), 32'd1);

        // Reset during data bit 4 of 0xFF, then a clean frame.
        send_bit(1'b0);
        repeat (4) send_bit(1'b1);
        tick(H);
        check("mid_busy", 32'(busy), 32'd1);
        rstn = 1'b0;
        tick(2);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_valid", 32'(rx_valid), 32'd0);
        check("midrst_data", 32'(rx_data), 32'd0);
        check("midrst_ferr", 32'(frame_err), 32'd0);
        rstn = 1'b1;
        tick(2 * CPB);
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 0);
        tick(4);
        check("final_pops", 32'(pops), 32'd5);
        check("final_queue", 32'(exp_q.size()), 32'd0);
        check("final_ferr", 32'(ferr_cnt), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
